// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a PAT_W-bit word MSB first, DIV clocks per bit.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit after the data bits.
module sequence_generator #(
    parameter int DIV   = 25000000,
    parameter int PAT_W = 4
) (
    input  logic             clk_50m,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    output logic             data_out,
    output logic             indication,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(DIV);
    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE_HALF = CW'(DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);

`ifdef SEQ_GEN_PARITY_EN
    typedef enum logic [1:0] {IDLE, SEND, PAR} state_t;
`else
    typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    presc_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [PAT_W-1:0] shreg_q;
    logic             done_q;
    logic             wrap;
    logic             last_bit;
    logic             frame_end;
`ifdef SEQ_GEN_PARITY_EN
    logic             par_q;
`endif

    assign wrap     = (presc_q == PRE_LAST);
    assign last_bit = (bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (wrap && last_bit) begin
`ifdef SEQ_GEN_PARITY_EN
                    state_d = PAR;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            PAR: begin
                if (wrap) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign frame_end = (state_q != IDLE) && (state_d == IDLE);

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            presc_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            done_q    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            done_q <= frame_end;
            if (state_q == IDLE) begin
                if (start) begin
                    shreg_q   <= pattern;
                    presc_q   <= '0;
                    bit_cnt_q <= '0;
`ifdef SEQ_GEN_PARITY_EN
                    par_q     <= ^pattern;
`endif
                end
            end else begin
                presc_q <= wrap ? '0 : presc_q + 1'b1;
                if (state_q == SEND && wrap && !last_bit) begin
                    shreg_q   <= shreg_q << 1;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
        end
    end

    // Outputs decode straight from state so reset clears them on the next cycle.
    always_comb begin
        data_out = 1'b0;
        case (state_q)
            SEND:    data_out = shreg_q[PAT_W-1];
`ifdef SEQ_GEN_PARITY_EN
            PAR:     data_out = par_q;
`endif
            default: data_out = 1'b0;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign indication = busy && (presc_q >= PRE_HALF);
    assign done       = done_q;

endmodule
